// File: rtl/execute_stage_mc_if.sv
// execute_stage_mc_if: decode-side request and memory-side result bundle of the execute stage
interface execute_stage_mc_if #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 4
);
  logic               in_valid, in_ready;
  logic               RegWrite, MemWrite, MemPWrite, IOFlag, BranchInst, ALUSrc, FlagWrite;
  logic [1:0]         MemToReg;
  logic [3:0]         ALUControl;
  logic [2:0]         CondFlag;
  logic [WIDTH-1:0]   Ra, Rb, ExtIm;
  logic [REGADDR-1:0] Rd;
  logic               out_valid, out_ready, PCSrc;
  logic               RegWriteOut, MemWriteOut, MemPWriteOut, IOFlagOut;
  logic [1:0]         MemToRegOut;
  logic [WIDTH-1:0]   ALUResult, WriteData;
  logic [REGADDR-1:0] RdOut;
  logic [3:0]         Flags;
  logic               busy;
  modport slave (
    input  in_valid, RegWrite, MemWrite, MemPWrite, IOFlag, BranchInst, ALUSrc, FlagWrite,
           MemToReg, ALUControl, CondFlag, Ra, Rb, ExtIm, Rd, out_ready,
    output in_ready, out_valid, PCSrc, RegWriteOut, MemWriteOut, MemPWriteOut, IOFlagOut,
           MemToRegOut, ALUResult, WriteData, RdOut, Flags, busy
  );
  modport master (
    output in_valid, RegWrite, MemWrite, MemPWrite, IOFlag, BranchInst, ALUSrc, FlagWrite,
           MemToReg, ALUControl, CondFlag, Ra, Rb, ExtIm, Rd, out_ready,
    input  in_ready, out_valid, PCSrc, RegWriteOut, MemWriteOut, MemPWriteOut, IOFlagOut,
           MemToRegOut, ALUResult, WriteData, RdOut, Flags, busy
  );
endinterface

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: condition-checked ALU execute stage with a shift-add multiplier and valid/ready output
module execute_stage_mc #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 4
) (
  input logic clk,
  input logic rst,
  execute_stage_mc_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0]   b, res, ma, mb, acc, res_q, wd_q, m_wd;
  logic [WIDTH:0]     sum, dif;
  logic [SW-1:0]      sh, cnt;
  logic [3:0]         flags, nf;
  logic [1:0]         m2r_q, m_m2r;
  logic [REGADDR-1:0] rd_q, m_rd;
  logic pass, is_mul, free, accept, start, load_op, load_mul, v_add, v_sub;
  logic out_valid, rw_q, mw_q, mpw_q, io_q, br_q;
  logic m_rw, m_mw, m_mpw, m_io, m_br, m_fw;
  assign b      = bus.ALUSrc ? bus.ExtIm : bus.Rb;
  assign sh     = b[SW-1:0];
  assign sum    = {1'b0, bus.Ra} + {1'b0, b};
  assign dif    = {1'b0, bus.Ra} - {1'b0, b};
  assign v_add  = (bus.Ra[M] == b[M]) & (sum[M] != bus.Ra[M]);
  assign v_sub  = (bus.Ra[M] != b[M]) & (dif[M] != bus.Ra[M]);
  assign is_mul = bus.ALUControl == 4'b1001;
  assign free   = !out_valid | bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready;
  assign start  = accept & is_mul & pass;
  // a squashed MUL takes the single-cycle path so it still emits a bundle
  assign load_op  = accept & !(is_mul & pass);
  assign load_mul = (state == DONE) & free;
  always_comb begin
    case (bus.ALUControl)
      4'b0000: res = bus.Ra & b;
      4'b0001: res = sum[M:0];
      4'b0010: res = dif[M:0];
      4'b0011: res = bus.Ra | b;
      4'b0100: res = bus.Ra ^ b;
      4'b0101: res = {{M{1'b0}}, $signed(bus.Ra) < $signed(b)};
      4'b0110: res = bus.Ra << sh;
      4'b0111: res = bus.Ra >> sh;
      4'b1000: res = WIDTH'($signed(bus.Ra) >>> sh);
      4'b1010: res = b;
      default: res = '0;
    endcase
  end
  always_comb begin
    case (bus.CondFlag)
      3'b000:  pass = 1'b1;
      3'b001:  pass = flags[2];
      3'b010:  pass = !flags[2];
      3'b011:  pass = flags[3] != flags[0];
      3'b100:  pass = flags[3] == flags[0];
      3'b101:  pass = flags[1];
      3'b110:  pass = !flags[1];
      default: pass = 1'b0;
    endcase
  end
  always_comb begin
    nf = flags;
    if (bus.FlagWrite) begin
      nf[3:2] = {res[M], res == '0};
      if (bus.ALUControl == 4'b0001) nf[1:0] = {sum[WIDTH], v_add};
      if (bus.ALUControl == 4'b0010) nf[1:0] = {!dif[WIDTH], v_sub};
    end
  end
  always_comb begin
    state_n = state == IDLE ? (start ? MUL : IDLE) :
              state == MUL  ? (cnt == SW'(M) ? DONE : MUL) :
              (free ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      res_q <= '0;
      wd_q <= '0;
      rd_q <= '0;
      m2r_q <= '0;
      {rw_q, mw_q, mpw_q, io_q, br_q} <= '0;
      flags <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
      m_wd <= '0;
      m_rd <= '0;
      m_m2r <= '0;
      {m_rw, m_mw, m_mpw, m_io, m_br, m_fw} <= '0;
    end else begin
      if (load_op) begin
        out_valid <= 1'b1;
        res_q <= res;
        wd_q <= bus.Rb;
        rd_q <= bus.Rd;
        m2r_q <= bus.MemToReg;
        {rw_q, mw_q, mpw_q, io_q, br_q} <= {bus.RegWrite, bus.MemWrite, bus.MemPWrite, bus.IOFlag, bus.BranchInst} & {5{pass}};
        if (pass) flags <= nf;
      end else if (load_mul) begin
        out_valid <= 1'b1;
        res_q <= acc;
        wd_q <= m_wd;
        rd_q <= m_rd;
        m2r_q <= m_m2r;
        {rw_q, mw_q, mpw_q, io_q, br_q} <= {m_rw, m_mw, m_mpw, m_io, m_br};
        if (m_fw) flags[3:2] <= {acc[M], acc == '0};
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
      // decode may change its inputs after accept, so the MUL keeps its own copy of the bundle
      if (start) begin
        ma <= bus.Ra;
        mb <= b;
        acc <= '0;
        cnt <= '0;
        m_wd <= bus.Rb;
        m_rd <= bus.Rd;
        m_m2r <= bus.MemToReg;
        {m_rw, m_mw, m_mpw, m_io, m_br, m_fw} <= {bus.RegWrite, bus.MemWrite, bus.MemPWrite, bus.IOFlag, bus.BranchInst, bus.FlagWrite};
      end else if (state == MUL) begin
        acc <= acc + (mb[cnt] ? ma << cnt : '0);
        cnt <= cnt + SW'(1);
      end
    end
  end
  assign bus.in_ready     = (state == IDLE) & free;
  assign bus.busy         = state != IDLE;
  assign bus.out_valid    = out_valid;
  assign bus.PCSrc        = out_valid & bus.out_ready & br_q;
  assign bus.ALUResult    = res_q;
  assign bus.WriteData    = wd_q;
  assign bus.RdOut        = rd_q;
  assign bus.MemToRegOut  = m2r_q;
  assign bus.RegWriteOut  = rw_q;
  assign bus.MemWriteOut  = mw_q;
  assign bus.MemPWriteOut = mpw_q;
  assign bus.IOFlagOut    = io_q;
  assign bus.Flags        = flags;
endmodule
